// File: rtl/usudp_pkg.sv
// ============================================================================
// Module      : usudp_pkg
// Description : Shared types and constants for the UDP transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usudp_pkg;

  localparam int LEN_W = 11;
  localparam int N_SRC = 4;

  localparam logic [1:0] SRC_DISC = 2'd0;
  localparam logic [1:0] SRC_EP6  = 2'd1;
  localparam logic [1:0] SRC_EP4  = 2'd2;
  localparam logic [1:0] SRC_AUX  = 2'd3;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // One-hot to index; an all-zero vector maps to 0.
  function automatic logic [1:0] oh2idx(input logic [N_SRC-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_SRC; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usudp_tx_arbiter_if.sv
// ============================================================================
// Module      : usudp_tx_arbiter_if
// Description : Source-side and UDP-stack-side signals of the transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usudp_tx_arbiter_if;
  import usudp_pkg::*;

  logic [N_SRC-1:0]       src_req;
  logic [N_SRC*LEN_W-1:0] src_length;
  logic [N_SRC*8-1:0]     src_data;
  logic [N_SRC-1:0]       src_enable;
  logic                   udp_tx_request;
  logic [LEN_W-1:0]       udp_tx_length;
  logic [7:0]             udp_tx_data;
  logic                   udp_tx_enable;
  logic [N_SRC-1:0]       grant;
  logic                   busy;

  modport master (
    input  src_req, src_length, src_data, udp_tx_enable,
    output src_enable, udp_tx_request, udp_tx_length, udp_tx_data, grant, busy
  );

  modport slave (
    output src_req, src_length, src_data, udp_tx_enable,
    input  src_enable, udp_tx_request, udp_tx_length, udp_tx_data, grant, busy
  );

endinterface

`default_nettype wire

// File: rtl/usudp_rr_pick3.sv
// ============================================================================
// Module      : usudp_rr_pick3
// Description : Combinational round-robin picker over sources 1..3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usudp_rr_pick3 (
  input  wire logic [2:0] i_cand,   // bit k = source k+1
  input  wire logic [1:0] i_ptr,    // 1..3
  output logic      [2:0] o_pick,
  output logic            o_valid
);

  logic [1:0] w_base;

  assign w_base = (i_ptr == 2'd0) ? 2'd0 : i_ptr - 2'd1;

  always_comb begin
    int s;
    o_pick  = '0;
    o_valid = 1'b0;
    s       = 0;
    for (int k = 0; k < 3; k++) begin
      s = int'(w_base) + k;
      if (s >= 3) s = s - 3;
      if (!o_valid && i_cand[s]) begin
        o_pick[s] = 1'b1;
        o_valid   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/usudp_tx_arbiter.sv
// ============================================================================
// Module      : usudp_tx_arbiter
// Description : Packet-level arbiter sharing one UDP transmit channel among
//               four sources; source 0 has priority, 1..3 are round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usudp_tx_arbiter
  import usudp_pkg::*;
#(
  parameter int GAP_CYCLES = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  usudp_tx_arbiter_if.master bus
);

  state_t           r_state, w_state_nxt;
  logic [N_SRC-1:0] r_grant, w_grant_nxt;
  len_t             r_len,   w_len_nxt;
  len_t             r_cnt,   w_cnt_nxt;
  logic [3:0]       r_gap,   w_gap_nxt;
  logic [1:0]       r_ptr,   w_ptr_nxt;

  logic [N_SRC-1:0] w_cand;
  logic [2:0]       w_rr_pick;
  logic             w_rr_vld;
  logic [N_SRC-1:0] w_pick_oh;
  logic             w_pick_vld;
  len_t             w_pick_len;
  logic [1:0]       w_gidx;

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_cand[i] = bus.src_req[i] && (bus.src_length[LEN_W*i +: LEN_W] != '0);
    end
  end

  usudp_rr_pick3 u_rr_pick3 (
    .i_cand  (w_cand[3:1]),
    .i_ptr   (r_ptr),
    .o_pick  (w_rr_pick),
    .o_valid (w_rr_vld)
  );

  assign w_pick_oh  = w_cand[SRC_DISC] ? 4'b0001 : {w_rr_pick, 1'b0};
  assign w_pick_vld = w_cand[SRC_DISC] | w_rr_vld;
  assign w_pick_len = bus.src_length[LEN_W*int'(oh2idx(w_pick_oh)) +: LEN_W];
  assign w_gidx     = oh2idx(r_grant);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_grant_nxt = w_pick_oh;
          w_len_nxt   = w_pick_len;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // Acceptance wins over a withdrawal seen in the same cycle.
        if (bus.udp_tx_enable) begin
          w_cnt_nxt   = r_len - len_t'(1);
          w_state_nxt = ST_XFER;
        end else if (!bus.src_req[w_gidx]) begin
          w_grant_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (r_cnt == '0) begin
          w_grant_nxt = '0;
          w_gap_nxt   = 4'(GAP_CYCLES - 1);
          w_state_nxt = ST_GAP;
          if (w_gidx != SRC_DISC) begin
            w_ptr_nxt = (w_gidx == SRC_AUX) ? SRC_EP6 : w_gidx + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - len_t'(1);
        end
      end
      ST_GAP: begin
        if (r_gap == 4'd0) w_state_nxt = ST_IDLE;
        else               w_gap_nxt   = r_gap - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_ptr   <= SRC_EP6;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign bus.udp_tx_request = (r_state == ST_REQ);
  assign bus.udp_tx_length  = r_len;
  assign bus.grant          = r_grant;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.src_enable     = (r_state == ST_REQ && bus.udp_tx_enable) ? r_grant : '0;
  assign bus.udp_tx_data    = (r_grant != '0) ? bus.src_data[8*int'(w_gidx) +: 8] : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_usudp_tx_arbiter.sv
// ============================================================================
// Module      : tb_usudp_tx_arbiter
// Description : Randomized self-checking bench with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usudp_tx_arbiter;

  localparam int GAP = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  bit [3:0]   rq;
  int         lens[4];
  logic [31:0] sd;
  int         ptr_m;

  usudp_tx_arbiter_if bus ();

  usudp_tx_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.src_req = rq;
    for (int i = 0; i < 4; i++) bus.src_length[11*i +: 11] = 11'(lens[i]);
    bus.src_data = sd;
  endtask

  task automatic set_src(input int i, input bit r, input int len);
    rq[i]   = r;
    lens[i] = len;
    drive();
  endtask

  // Packet-level scheduling rule: source 0 first, then 1..3 from the pointer.
  function automatic int predict();
    int s;
    if (rq[0] && lens[0] != 0) return 0;
    for (int k = 0; k < 3; k++) begin
      s = 1 + ((ptr_m - 1 + k) % 3);
      if (rq[s] && lens[s] != 0) return s;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rq  = '0;
    bus.udp_tx_enable = 1'b0;
    drive();
    @(negedge clk);
    rst   = 1'b0;
    ptr_m = 1;
  endtask

  // Entered at a negedge with the DUT idle and requests already driven.
  task automatic run_packet(input int src, input bit drop, input bit scramble, input int abort_at);
    int l, d, cnt, g;
    l = lens[src];
    @(negedge clk);
    chk("latency_req", 32'(bus.udp_tx_request), 32'd1);
    chk("grant", 32'(bus.grant), 32'(1 << src));
    chk("length", 32'(bus.udp_tx_length), 32'(l));
    d = $urandom_range(0, 3);
    repeat (d) begin
      chk("src_en_idle", 32'(bus.src_enable), 32'd0);
      @(negedge clk);
    end
    bus.udp_tx_enable = 1'b1;
    #1;
    chk("src_en", 32'(bus.src_enable), 32'(1 << src));
    @(negedge clk);
    bus.udp_tx_enable = 1'b0;
    if (drop) rq[src] = 1'b0;
    if (scramble) begin
      for (int i = 0; i < 4; i++) lens[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
    end
    drive();
    cnt = 0;
    while (bus.grant != '0 && cnt < 2100) begin
      if (cnt == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(bus.udp_tx_request), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_len", 32'(bus.udp_tx_length), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ptr_m = 1;
        return;
      end
      chk("xfer_req", 32'(bus.udp_tx_request), 32'd0);
      chk("data", 32'(bus.udp_tx_data), 32'(sd[8*src +: 8]));
      sd = $urandom;
      drive();
      cnt++;
      @(negedge clk);
    end
    chk("xfer_clocks", 32'(cnt), 32'(l));
    g = 0;
    while (bus.busy && g < 100) begin
      chk("gap_data", 32'(bus.udp_tx_data), 32'd0);
      g++;
      @(negedge clk);
    end
    chk("gap_clocks", 32'(g), 32'(GAP));
    chk("idle_grant", 32'(bus.grant), 32'd0);
    if (src != 0) ptr_m = (src % 3) + 1;
  endtask

  initial begin
    int e;
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    rq      = '0;
    sd      = '0;
    ptr_m   = 1;
    for (int i = 0; i < 4; i++) lens[i] = 0;
    bus.udp_tx_enable = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    chk("reset_req", 32'(bus.udp_tx_request), 32'd0);
    chk("reset_grant", 32'(bus.grant), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_len", 32'(bus.udp_tx_length), 32'd0);
    chk("reset_data", 32'(bus.udp_tx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single EP6 packet of 1032 bytes.
    set_src(1, 1'b1, 1032);
    run_packet(predict(), 1'b1, 1'b0, -1);

    // Priority: 0, 1, 2 request together from a fresh pointer.
    do_reset();
    set_src(0, 1'b1, 60);
    set_src(1, 1'b1, $urandom_range(1, 20));
    set_src(2, 1'b1, $urandom_range(1, 20));
    for (int p = 0; p < 3; p++) begin
      e = predict();
      if (e >= 0) run_packet(e, 1'b1, 1'b0, -1);
    end

    // Fairness: 1, 2, 3 held continuously.
    do_reset();
    for (int i = 1; i < 4; i++) set_src(i, 1'b1, $urandom_range(1, 12));
    for (int p = 0; p < 6; p++) begin
      e = predict();
      if (e >= 0) run_packet(e, 1'b0, 1'b0, -1);
    end
    rq = '0;
    drive();

    // Withdraw in REQ, then re-request alongside competitors.
    do_reset();
    set_src(1, 1'b1, 20);
    @(negedge clk);
    chk("wd_req", 32'(bus.udp_tx_request), 32'd1);
    chk("wd_grant", 32'(bus.grant), 32'd2);
    set_src(1, 1'b0, 20);
    @(negedge clk);
    chk("wd_busy", 32'(bus.busy), 32'd0);
    chk("wd_grant0", 32'(bus.grant), 32'd0);
    set_src(1, 1'b1, 20);
    set_src(2, 1'b1, 7);
    set_src(3, 1'b1, 9);
    run_packet(predict(), 1'b1, 1'b0, -1);
    rq = '0;
    drive();

    // Reset at byte 500 of 1032, then a fresh packet.
    do_reset();
    set_src(1, 1'b1, 1032);
    run_packet(predict(), 1'b1, 1'b0, 500);
    set_src(2, 1'b1, $urandom_range(1, 20));
    e = predict();
    if (e >= 0) run_packet(e, 1'b1, 1'b0, -1);

    // Zero-length request never granted; maximum length runs 2047 clocks.
    set_src(3, 1'b1, 0);
    set_src(2, 1'b1, 2047);
    e = predict();
    if (e >= 0) run_packet(e, 1'b1, 1'b0, -1);
    repeat (8) begin
      @(negedge clk);
      chk("zero_len_idle", 32'(bus.busy), 32'd0);
    end
    rq = '0;
    drive();

    // Random rounds.
    for (int r = 0; r < 25; r++) begin
      rq = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) lens[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
      drive();
      e = predict();
      if (e < 0) begin
        repeat (3) begin
          @(negedge clk);
          chk("rand_idle", 32'(bus.busy), 32'd0);
        end
      end else begin
        run_packet(e, 1'($urandom_range(0, 1)), 1'b1, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/usudp_tx_arbiter.md
# usudp_tx_arbiter

Schedules the single UDP/IP transmit channel between four upstream packet sources: discovery/response, EP6 receive data, EP4 wideband, and an auxiliary source. It sits between the source packers and the Ethernet UDP transmit stack. It selects one source per packet, presents that source's length and request to the stack, and forwards the stack's enable and that source's data bytes. It holds the channel for exactly the announced byte count, then enforces an inter-packet gap.

## Interface
- `GAP_CYCLES`, default 4: idle clocks between the end of one packet and the next arbitration (1..15).
- `clk`  in  1: system clock; every register is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `src_req`  in  4: per-source packet request, level; bit 0 discovery, 1 EP6, 2 EP4, 3 aux.
- `src_length`  in  44: per-source packet length in bytes, 11 bits each; source i occupies bits [11i+10:11i].
- `src_data`  in  32: per-source byte stream, 8 bits each; source i occupies bits [8i+7:8i].
- `src_enable`  out  4: per-source enable, `udp_tx_enable` gated to the granted source while in REQ.
- `udp_tx_request`  out  1: request to the UDP stack; reset 0.
- `udp_tx_length`  out  11: registered length of the granted packet; reset 0.
- `udp_tx_data`  out  8: data byte from the granted source; 0 when no source is granted.
- `udp_tx_enable`  in  1: acceptance from the UDP stack.
- `grant`  out  4: one-hot granted source; reset 0.
- `busy`  out  1: high in every state except IDLE; reset 0.

## Operation
- FSM states: IDLE, REQ, XFER, GAP. Reset state is IDLE. The round-robin pointer resets to 1 and the counters reset to 0.
- IDLE: the candidate set is the sources with `src_req` high and a nonzero length. Zero-length requests are never granted.
  - Source 0 has strict priority.
  - Otherwise pick among sources 1..3 round-robin, starting at the pointer and wrapping 3 to 1.
  - On a pick: load `grant`, register `udp_tx_length` from the picked source's length, then go to REQ.
  - With no candidate, stay in IDLE.
- REQ: `udp_tx_request` is 1. `src_enable[g]` = `udp_tx_enable`.
  - If the granted source drops `src_req` before `udp_tx_enable` arrives, the request is withdrawn: clear `grant`, go to IDLE. The pointer does not move.
  - On `udp_tx_enable`: load the byte counter with length-1 and go to XFER.
- XFER: `udp_tx_request` is 0 and `udp_tx_data` = `src_data[g]`. The counter decrements every clock. When the counter reaches 0:
  - go to GAP and load the gap counter with `GAP_CYCLES`-1;
  - if the granted source was 1..3, move the pointer to g+1, wrapping 3 to 1; source 0 leaves the pointer unchanged.
- GAP: `grant` is cleared on entry. Count down to 0, then go to IDLE.
- Request changes or length changes during XFER or GAP are ignored until the next IDLE.
- The length register and counter are 11 bits. The maximum length 2047 produces 2047 data clocks.

## Timing
- `src_req` sampled in IDLE gives `udp_tx_request` high on the next clock. Minimum latency is 1 clock.
- `src_enable` is combinational from `udp_tx_enable`, so the source sees the enable in the same cycle as the stack.
- The first data byte is presented in the clock after `udp_tx_enable`. Sources must drive byte 0 then, matching the existing packer convention of loading the next byte on enable.
- XFER lasts exactly `udp_tx_length` clocks.
- Back-to-back packets are separated by `GAP_CYCLES` + 1 clocks: GAP plus IDLE.
- Asynchronous reset during any state immediately forces IDLE, and all outputs go to their reset values. An in-flight packet is truncated; the UDP stack handles its own abort.

## Structure
- Shared package `usudp_pkg` holds:
  - the source index constants `SRC_DISC`=0, `SRC_EP6`=1, `SRC_EP4`=2, `SRC_AUX`=3;
  - the state enum;
  - the 11-bit length type.
- Sub-module `usudp_rr_pick3`: a combinational round-robin picker over sources 1..3. Inputs: candidate mask and pointer. Outputs: one-hot pick and valid.

## Test plan
- **Single source.** EP6 requests length 1032. Expected: `udp_tx_length` = 1032 and request high one clock later. Drive `udp_tx_enable`; XFER lasts exactly 1032 clocks. Then 4 gap clocks, IDLE, and `grant` = 0.
- **Priority.** Sources 0, 1 and 2 request in the same clock. Expected: source 0 (length 60) is granted first, then source 1, then source 2. The pointer ends at 3.
- **Fairness.** Sources 1, 2 and 3 request continuously. Expected grant order: 1, 2, 3, 1, 2, 3. No source waits more than two packets.
- **Withdraw.** The granted source drops `src_req` in REQ before `udp_tx_enable`. Expected: the next clock is IDLE, the pointer is unchanged, and the same source is re-granted when it requests again.
- **Reset mid-packet.** Assert `rst` at byte 500 of a 1032-byte packet. Expected: `udp_tx_request`, `grant` and `busy` are 0 immediately. After release, a fresh request is granted normally.
- **Zero length and maximum length.** A source requests with length 0. Expected: never granted while another source with length 2047 completes exactly 2047 data clocks.
